// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the sequenced reset block.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } rstseq_state_t;

  // One counter serves both the stretch and the gap phases, so it must hold the larger.
  function automatic int cnt_width(input int stretch, input int gap);
    int m;
    m = (stretch > gap) ? stretch : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-assert / sync-release reset synchroniser; NSTAGES cycles from aresetn rise to sync_rst fall.
module reset_sync_chain #(
  parameter int NSTAGES = 3
) (
  input  logic clock,
  input  logic aresetn,
  output logic sync_rst
);

  logic [NSTAGES-1:0] chain;

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      chain <= '1;
    end else begin
      chain <= {chain[NSTAGES-2:0], 1'b0};
    end
  end

  assign sync_rst = chain[NSTAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Stretches the synchronised reset, then releases NCHAN domain resets in order, GAP cycles apart.
// Outputs are registered; chan_hold defers a due release, swrst_req restarts from the stretch phase.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int NCHAN   = 4,
  parameter int STRETCH = 16,
  parameter int GAP     = 8
) (
  input  logic             clock,
  input  logic             aresetn,
  input  logic             swrst_req,
  input  logic [NCHAN-1:0] chan_hold,
  output logic [NCHAN-1:0] sreset,
  output logic             done
);

  localparam int CW = cnt_width(STRETCH, GAP);
  localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [CW-1:0] STRETCH_LD = CW'(STRETCH - 1);
  // The edge that first samples sync_rst low is already the first stretch cycle.
  localparam logic [CW-1:0] FIRST_LD   = (STRETCH > 1) ? CW'(STRETCH - 2) : '0;
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NCHAN - 1);

  logic             sync_rst;
  rstseq_state_t    state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [IW-1:0]    idx, idx_d;
  logic [NCHAN-1:0] sreset_d;
  logic             done_d;
  logic             hold_cur;
  logic             due;

  reset_sync_chain #(
    .NSTAGES(NSTAGES)
  ) u_sync (
    .clock    (clock),
    .aresetn  (aresetn),
    .sync_rst (sync_rst)
  );

  always_comb begin
    hold_cur = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (idx == IW'(i)) hold_cur = chan_hold[i];
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    sreset_d = sreset;
    done_d   = done;
    due      = 1'b0;

    case (state)
      ST_ASSERT: begin
        if (!sync_rst) begin
          if (STRETCH == 1) begin
            due = 1'b1;
          end else begin
            state_d = ST_STRETCH;
            cnt_d   = FIRST_LD;
          end
        end
      end
      ST_STRETCH, ST_RELEASE: begin
        if (cnt == '0) due = 1'b1;
        else           cnt_d = cnt - CW'(1);
      end
      default: ;
    endcase

    // A held channel parks the counter at zero so it stays due every edge.
    if (due) begin
      if (hold_cur) begin
        state_d = ST_RELEASE;
        cnt_d   = '0;
      end else begin
        for (int i = 0; i < NCHAN; i++) begin
          if (idx == IW'(i)) sreset_d[i] = 1'b0;
        end
        if (idx == LAST_IDX) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RELEASE;
          idx_d   = idx + IW'(1);
          cnt_d   = GAP_LD;
        end
      end
    end

    if (swrst_req && state != ST_ASSERT) begin
      state_d  = ST_STRETCH;
      cnt_d    = STRETCH_LD;
      idx_d    = '0;
      sreset_d = '1;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state  <= ST_ASSERT;
      cnt    <= '0;
      idx    <= '0;
      sreset <= '1;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      sreset <= sreset_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default config plus a minimal single-channel instance.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       aresetn;
  logic       swrst_req;
  logic [3:0] chan_hold;
  logic [3:0] sreset;
  logic       done;

  logic       aresetn6;
  logic [0:0] sreset6;
  logic       done6;

  always #5 clock = ~clock;

  reset_sequencer #(
    .NSTAGES(3), .NCHAN(4), .STRETCH(16), .GAP(8)
  ) dut (
    .clock     (clock),
    .aresetn   (aresetn),
    .swrst_req (swrst_req),
    .chan_hold (chan_hold),
    .sreset    (sreset),
    .done      (done)
  );

  reset_sequencer #(
    .NSTAGES(2), .NCHAN(1), .STRETCH(1), .GAP(1)
  ) dut6 (
    .clock     (clock),
    .aresetn   (aresetn6),
    .swrst_req (1'b0),
    .chan_hold (1'b0),
    .sreset    (sreset6),
    .done      (done6)
  );

  // rel = edges since the sequence origin (t0 for aresetn, t1 for swrst_req)
  typedef struct {
    int         rel;
    logic [3:0] sr;
    logic       dn;
  } vec_t;

  vec_t tbl [9];
  int   rel;
  int   n_chk;
  int   n_pass;

  task automatic step();
    @(posedge clock);
    #1;
    rel++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_table(input int upto, input string tag);
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rel <= upto) begin
        while (rel < tbl[i].rel) step();
        chk($sformatf("%s sreset@%0d", tag, tbl[i].rel), 32'(sreset), 32'(tbl[i].sr));
        chk($sformatf("%s done@%0d", tag, tbl[i].rel), 32'(done), 32'(tbl[i].dn));
      end
    end
  endtask

  task automatic restart();
    @(negedge clock);
    aresetn = 1'b0;
    @(negedge clock);
    aresetn = 1'b1;
    rel = -3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{15, 4'b1111, 1'b0};
    tbl[1] = '{16, 4'b1110, 1'b0};
    tbl[2] = '{23, 4'b1110, 1'b0};
    tbl[3] = '{24, 4'b1100, 1'b0};
    tbl[4] = '{31, 4'b1100, 1'b0};
    tbl[5] = '{32, 4'b1000, 1'b0};
    tbl[6] = '{39, 4'b1000, 1'b0};
    tbl[7] = '{40, 4'b0000, 1'b1};
    tbl[8] = '{42, 4'b0000, 1'b1};

    n_chk     = 0;
    n_pass    = 0;
    rel       = 0;
    aresetn   = 1'b0;
    aresetn6  = 1'b0;
    swrst_req = 1'b0;
    chan_hold = 4'b0000;

    repeat (5) @(posedge clock);
    #1;
    chk("reset sreset", 32'(sreset), 32'h f);
    chk("reset done", 32'(done), 32'h0);
    chk("reset sreset6", 32'(sreset6), 32'h1);
    chk("reset done6", 32'(done6), 32'h0);

    // Power-up sequence
    @(negedge clock);
    aresetn = 1'b1;
    rel = -3;
    step();
    step();
    chk("sync high before t0", 32'(dut.u_sync.sync_rst), 32'h1);
    step();
    chk("sync low at t0", 32'(dut.u_sync.sync_rst), 32'h0);
    run_table(100, "pwr");

    // One-cycle software reset from RUN
    @(negedge clock);
    swrst_req = 1'b1;
    step();
    swrst_req = 1'b0;
    rel = 0;
    chk("swrst sreset@t1", 32'(sreset), 32'h f);
    chk("swrst done@t1", 32'(done), 32'h0);
    run_table(100, "swrst");

    // 1 ns aresetn glitch mid-release, then full restart
    restart();
    while (rel < 27) step();
    chk("mid release sreset", 32'(sreset), 32'h c);
    #1 aresetn = 1'b0;
    #1;
    chk("async sreset", 32'(sreset), 32'h f);
    chk("async done", 32'(done), 32'h0);
    aresetn = 1'b1;
    rel = -3;
    run_table(100, "glitch");

    // Channel 2 held past its due edge
    chan_hold = 4'b0100;
    restart();
    while (rel < 60) begin
      step();
      case (rel)
        16: chk("hold ch0", 32'(sreset), 32'h e);
        24: chk("hold ch1", 32'(sreset), 32'h c);
        32: chk("hold ch2 due", 32'(sreset), 32'h c);
        50: begin
          chk("hold ch2 last held", 32'(sreset), 32'h c);
          chan_hold = 4'b0000;
        end
        51: chk("hold ch2 release", 32'(sreset), 32'h8);
        58: begin
          chk("hold ch3 before", 32'(sreset), 32'h8);
          chk("hold done before", 32'(done), 32'h0);
        end
        59: begin
          chk("hold ch3 release", 32'(sreset), 32'h0);
          chk("hold done", 32'(done), 32'h1);
        end
        default: ;
      endcase
    end

    // swrst_req on the very edge ch1 is due
    restart();
    while (rel < 23) step();
    chk("pre-due sreset", 32'(sreset), 32'h e);
    swrst_req = 1'b1;
    step();
    swrst_req = 1'b0;
    rel = 0;
    chk("due+swrst sreset", 32'(sreset), 32'h f);
    chk("due+swrst done", 32'(done), 32'h0);
    run_table(100, "due-swrst");

    // Minimal configuration
    @(negedge clock);
    aresetn6 = 1'b1;
    step();
    chk("min e1 sreset", 32'(sreset6), 32'h1);
    step();
    chk("min e2 sreset", 32'(sreset6), 32'h1);
    chk("min e2 done", 32'(done6), 32'h0);
    step();
    chk("min e3 sreset", 32'(sreset6), 32'h0);
    chk("min e3 done", 32'(done6), 32'h1);
    chk("min no X", 32'($isunknown({sreset6, done6})), 32'h0);
    step();
    step();
    chk("min stays released", 32'({sreset6, done6}), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
